// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts and a
// bit-serial first-difference scan, with a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01111;
  localparam logic [4:0] OP_COMP = 5'b01100;
  localparam logic [4:0] OP_DIFF = 5'b10000;

  typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_shifted;
  logic [4:0]       cnt;
  logic [4:0]       idx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] imm_result;
  logic             imm_carry;
  logic             imm_err;
  logic             is_shift;
  logic             bit_diff;

  // Results for everything that completes straight out of IDLE, computed
  // from the live inputs so they can be registered on the accepting edge.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    imm_result = '0;
    imm_carry  = 1'b0;
    imm_err    = 1'b0;
    is_shift   = 1'b0;
    case (ctrl)
      OP_ADD: begin
        imm_result = sum[WIDTH-1:0];
        imm_carry  = sum[WIDTH];
      end
      OP_AND:  imm_result = a & b;
      OP_XOR:  imm_result = a ^ b;
      OP_COMP: imm_result = ~b + WIDTH'(1);
      OP_SLL, OP_SRL, OP_SRA: begin
        imm_result = a;
        is_shift   = 1'b1;
      end
      OP_DIFF: imm_result = '0;
      default: imm_err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
      default: acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
    bit_diff = a_q[idx] ^ b_q[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (ctrl == OP_DIFF)                 state_nxt = SCAN;
          else if (is_shift && b[4:0] != 5'd0) state_nxt = SHIFT;
          else                                 state_nxt = DONE;
        end
      end
      SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
      SCAN:    if (bit_diff || idx == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Output registers are only written on the edge that enters DONE, so they
  // hold their last values through IDLE and the next operation's busy time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      idx    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= ctrl;
            acc  <= a;
            cnt  <= b[4:0];
            idx  <= '0;
            if (state_nxt == DONE) begin
              result <= imm_result;
              zero   <= (imm_result == '0);
              carry  <= imm_carry;
              err    <= imm_err;
            end
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= acc_shifted;
            zero   <= (acc_shifted == '0);
            carry  <= 1'b0;
            err    <= 1'b0;
          end
        end
        SCAN: begin
          idx <= idx + 5'd1;
          if (bit_diff) begin
            result <= WIDTH'(idx);
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
          end else if (idx == 5'd31) begin
            result <= WIDTH'(WIDTH);
            zero   <= 1'b1;
            carry  <= 1'b0;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: latency, busy length, flags, operand
// latching, ignored starts and mid-operation reset.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .result(result), .zero(zero), .carry(carry), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] c, input logic [31:0] av,
                               input logic [31:0] bv);
    ctrl  = c;
    a     = av;
    b     = bv;
    start = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after done,
  // so consecutive calls issue back-to-back starts.
  task automatic runOp(input string tag, input logic [4:0] c,
                       input logic [31:0] av, input logic [31:0] bv,
                       input int expCycles, input logic [31:0] expResult,
                       input logic expZero, input logic expCarry,
                       input logic expErr, input int pokeCycle);
    int seen = 0;
    int busyCycles = 0;
    applyStimulus(c, av, bv);
    @(posedge clk);
    for (int k = 1; k <= expCycles + 4 && seen == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        ctrl  = c ^ 5'h1f;
      end
      if (k == pokeCycle) begin
        start = 1'b1;
        ctrl  = 5'b00000;
        a     = 32'h0000_0001;
        b     = 32'h0000_0001;
      end else if (k == pokeCycle + 1) begin
        start = 1'b0;
      end
      if (busy) busyCycles++;
      if (done) begin
        seen = k;
        checkOutput({tag, "_result"}, result, expResult);
        checkOutput({tag, "_zero"}, 32'(zero), 32'(expZero));
        checkOutput({tag, "_carry"}, 32'(carry), 32'(expCarry));
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
      end
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(seen), 32'(expCycles));
    checkOutput({tag, "_busycycles"}, 32'(busyCycles), 32'(expCycles));
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hold"}, result, expResult);
  endtask

  initial begin
    int doneDuringReset;
    rst   = 1'b0;
    start = 1'b0;
    ctrl  = 5'b0;
    a     = 32'h0;
    b     = 32'h0;
    @(negedge clk);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_flags", {26'h0, zero, carry, err, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    runOp("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 0);
    runOp("add_small", 5'b00000, 32'h0000_0007, 32'h0000_0008, 1, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 0);
    runOp("and", 5'b00001, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 0);
    runOp("xor", 5'b00010, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 0);
    runOp("comp", 5'b01100, 32'h1234_5678, 32'h0000_0005, 1, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 0);
    runOp("sra4", 5'b01111, 32'h8000_0000, 32'h0000_0004, 5, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 0);
    runOp("sra0", 5'b01111, 32'h8000_0000, 32'h0000_0000, 1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0);
    runOp("srl4", 5'b00111, 32'h8000_0000, 32'h0000_0004, 5, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 0);
    runOp("srl_to_zero", 5'b00111, 32'h0000_0001, 32'h0000_0001, 2, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
    runOp("sll31_poke", 5'b00011, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 10);
    runOp("diff_bit4", 5'b10000, 32'h0000_0010, 32'h0000_0000, 6, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 0);
    runOp("diff_bit0", 5'b10000, 32'h0000_0001, 32'h0000_0000, 2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
    runOp("diff_equal", 5'b10000, 32'h1234_5678, 32'h1234_5678, 33, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 0);
    runOp("illegal", 5'b10101, 32'hDEAD_BEEF, 32'h0000_0003, 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);

    // Abort a shift in its third SHIFT cycle; flags from the illegal op are set.
    applyStimulus(5'b00011, 32'h0000_0003, 32'h0000_000A);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midop_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midop_result", result, 32'h0);
    checkOutput("midop_flags", {26'h0, zero, carry, err, busy, done}, 32'h0);
    doneDuringReset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) doneDuringReset++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) doneDuringReset++;
    end
    checkOutput("midop_nodone", 32'(doneDuringReset), 32'd0);

    runOp("comp_after_rst", 5'b01100, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported, and REQ-019 depends on it.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request strobe; accepted only in IDLE.
REQ-005 Port: ctrl  input  5  ALU control code from the ALU control decoder.
REQ-006 Port: a  input  WIDTH  operand A (rs).
REQ-007 Port: b  input  WIDTH  operand B (rt or immediate); b[4:0] is the shift amount.
REQ-008 Port: result  output  WIDTH  registered result.
REQ-009 Port: zero  output  1  registered zero flag.
REQ-010 Port: carry  output  1  registered carry-out, meaningful for add only.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: done  output  1  one-cycle pulse; result, zero, carry and err are valid in that cycle.
REQ-013 Port: err  output  1  illegal ctrl code flag, valid with done.

Function
REQ-014 States SHALL be IDLE, SHIFT, SCAN and DONE.
- DONE lasts exactly one cycle, drives done=1, then returns to IDLE.
REQ-015 On start=1 in IDLE, the block SHALL latch a, b and ctrl; later changes to these inputs have no effect until the next accepted start.
REQ-016 start while busy=1 SHALL be ignored without error.
REQ-017 Single-cycle codes (start accepted at edge T, result registered at T+1, state DONE, done=1 during cycle T+1):
- 00000 add: result=a+b mod 2^32, carry=bit 32 of the sum.
- 00001 and: result=a&b.
- 00010 xor: result=a^b.
- 01100 comp: result=~b+1 (two's complement of b).
REQ-018 Shift codes SHALL move one bit per cycle in SHIFT:
- Codes: 00011 sll a, 00111 srl a (zero fill), 01111 sra a (sign fill).
- Shift amount is sh=b[4:0].
- sh=0: go directly to DONE with result=a; done at T+1.
- Otherwise: done at T+1+sh.
REQ-019 Code 10000 diff SHALL scan bit i=0,1,... one bit per cycle in SCAN:
- First i with a[i]!=b[i]: result=i, zero=0, done at T+2+i.
- a==b: result=32, zero=1, done at T+33.
REQ-020 Zero flag for all codes except diff: zero=(result==0).
REQ-021 carry SHALL be 0 for every code except add.
REQ-022 Any other ctrl value SHALL give result=0, zero=1, err=1, with done at T+1.
- err is 0 for all legal codes.
REQ-023 result, zero, carry and err SHALL hold their values after done until the next accepted start updates them.
REQ-024 The cycle after done SHALL be IDLE; a start in that cycle is accepted.
- Back-to-back ops therefore run with one IDLE cycle between done pulses.

Reset
REQ-025 rst=0 SHALL immediately force:
- state=IDLE;
- result=0, zero=0, carry=0, err=0, busy=0, done=0;
- internal counters and latched operands to 0.
REQ-026 Reset asserted mid-operation (SHIFT, SCAN or DONE) SHALL abort the operation with no done pulse.
- After rst returns to 1, the first start is accepted normally.

Verification
REQ-027 Add: a=FFFFFFFF, b=00000001, ctrl=00000 -> done at T+1, result=0, carry=1, zero=1, err=0.
REQ-028 sra: a=80000000, b=00000004, ctrl=01111 -> busy for 5 cycles, done at T+5, result=F8000000.
- Repeat with b=0: done at T+1, result=80000000.
REQ-029 diff:
- a=00000010, b=00000000 -> done at T+6, result=4, zero=0.
- a=b=12345678 -> done at T+33, result=32, zero=1.
REQ-030 Illegal and protocol cases:
- ctrl=10101 -> done at T+1, err=1, result=0.
- start pulsed during a 31-cycle sll -> ignored; original result is delivered unchanged.
REQ-031 Reset mid-op: assert rst=0 in the third cycle of SHIFT -> outputs 0 at once and no done pulse.
- After release, comp b=00000001 -> result=FFFFFFFF at T+1.
